// File: rtl/aq_pkg.sv
// Shared types and default constants for the multi-room air quality controller.
package aq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PURIFY   = 2'd1,
    ST_HUMIDIFY = 2'd2,
    ST_FAULT    = 2'd3
  } aq_state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_N_CH    = 4;
  localparam int DEF_HUM_ON  = 30;
  localparam int DEF_HUM_OFF = 40;
  localparam int DEF_PUR_OFF = 80;
  localparam int DEF_PUR_ON  = 100;
  localparam int DEF_PERSIST = 3;
  localparam int DEF_MIN_ON  = 1000;
  localparam int DEF_TIMEOUT = 100000;

  // Room-index width; a single room still gets a one-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/air_quality_controller_if.sv
// Sample bus from the sensor sampler plus the per-room actuator/fault vectors.
interface air_quality_controller_if
  import aq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_CH  = DEF_N_CH
) ();
  localparam int CH_W = ch_w(N_CH);

  logic              sample_valid;
  logic [CH_W-1:0]   sample_ch;
  logic [WIDTH-1:0]  sample;
  logic [N_CH-1:0]   purifier;
  logic [N_CH-1:0]   humidifier;
  logic [N_CH-1:0]   fault;

  modport master (
    output sample_valid, sample_ch, sample,
    input  purifier, humidifier, fault
  );

  modport slave (
    input  sample_valid, sample_ch, sample,
    output purifier, humidifier, fault
  );
endinterface

// File: rtl/aq_channel_fsm.sv
// One room: hysteresis FSM with persistence filter, minimum on-time and
// stale-sensor watchdog. Outputs are registered from the next state.
module aq_channel_fsm
  import aq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HUM_ON  = DEF_HUM_ON,
  parameter int HUM_OFF = DEF_HUM_OFF,
  parameter int PUR_OFF = DEF_PUR_OFF,
  parameter int PUR_ON  = DEF_PUR_ON,
  parameter int PERSIST = DEF_PERSIST,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic [WIDTH-1:0] sample,
  output logic             purifier,
  output logic             humidifier,
  output logic             fault
);
  localparam int PW = $clog2(PERSIST + 1);
  localparam int TW = $clog2(MIN_ON + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0] HUM_ON_C  = WIDTH'(HUM_ON);
  localparam logic [WIDTH-1:0] HUM_OFF_C = WIDTH'(HUM_OFF);
  localparam logic [WIDTH-1:0] PUR_OFF_C = WIDTH'(PUR_OFF);
  localparam logic [WIDTH-1:0] PUR_ON_C  = WIDTH'(PUR_ON);
  localparam logic [PW-1:0]    PERSIST_C = PW'(PERSIST);
  localparam logic [TW-1:0]    MIN_ON_C  = TW'(MIN_ON);
  localparam logic [WW-1:0]    TIMEOUT_C = WW'(TIMEOUT);
  localparam logic [WW-1:0]    WDOG_LAST = WW'(TIMEOUT - 1);

  aq_state_e       state, state_nxt;
  logic [PW-1:0]   cnt, cnt_nxt, cnt_inc, run;
  logic            dir, dir_nxt;
  logic [TW-1:0]   on_tmr, on_tmr_nxt, tmr_inc;
  logic [WW-1:0]   wdog, wdog_nxt, wdog_inc;
  logic            is_hi, is_lo, pur_rel, hum_rel, rel, tmr_done, wdog_exp;

  assign is_hi    = (sample >= PUR_ON_C);
  assign is_lo    = (sample <  HUM_ON_C);
  assign pur_rel  = (sample <  PUR_OFF_C);
  assign hum_rel  = (sample >= HUM_OFF_C);
  assign rel      = (state == ST_PURIFY) ? pur_rel : hum_rel;

  assign cnt_inc  = (cnt == PERSIST_C) ? cnt : cnt + 1'b1;
  assign tmr_inc  = (on_tmr == MIN_ON_C) ? on_tmr : on_tmr + 1'b1;
  assign wdog_inc = (wdog == TIMEOUT_C) ? wdog : wdog + 1'b1;
  assign tmr_done = (on_tmr >= MIN_ON_C);
  assign wdog_exp = (wdog >= WDOG_LAST);

  // In IDLE one counter serves both directions; dir remembers which run it holds.
  assign run = ((dir == is_hi) && (cnt != '0)) ? cnt_inc : PW'(1);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_nxt    = dir;
    on_tmr_nxt = on_tmr;
    wdog_nxt   = hit ? '0 : wdog_inc;
    case (state)
      ST_FAULT: begin
        if (hit) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (hit) begin
          if (is_hi || is_lo) begin
            cnt_nxt = run;
            dir_nxt = is_hi;
            if (run >= PERSIST_C) state_nxt = is_hi ? ST_PURIFY : ST_HUMIDIFY;
          end else begin
            cnt_nxt = '0;
          end
        end else if (wdog_exp) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_PURIFY, ST_HUMIDIFY: begin
        on_tmr_nxt = tmr_inc;
        if (hit) begin
          if (rel) begin
            cnt_nxt = cnt_inc;
            if ((cnt_inc >= PERSIST_C) && tmr_done) state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = '0;
          end
        end else if (wdog_exp) begin
          state_nxt = ST_FAULT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Any state entry starts with a clean filter and timer.
    if (state_nxt != state) begin
      cnt_nxt    = '0;
      dir_nxt    = 1'b0;
      on_tmr_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dir        <= 1'b0;
      on_tmr     <= '0;
      wdog       <= '0;
      purifier   <= 1'b0;
      humidifier <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      on_tmr     <= on_tmr_nxt;
      wdog       <= wdog_nxt;
      purifier   <= (state_nxt == ST_PURIFY);
      humidifier <= (state_nxt == ST_HUMIDIFY);
      fault      <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: rtl/air_quality_controller.sv
// Multi-room air quality controller: decodes the room index of each sample
// and fans it out to one channel FSM per room.
module air_quality_controller
  import aq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_CH    = DEF_N_CH,
  parameter int HUM_ON  = DEF_HUM_ON,
  parameter int HUM_OFF = DEF_HUM_OFF,
  parameter int PUR_OFF = DEF_PUR_OFF,
  parameter int PUR_ON  = DEF_PUR_ON,
  parameter int PERSIST = DEF_PERSIST,
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  air_quality_controller_if.slave  bus
);
  localparam int CH_W = ch_w(N_CH);

  if (!((HUM_ON <= HUM_OFF) && (HUM_OFF < PUR_OFF) && (PUR_OFF <= PUR_ON))) begin : g_bad_thresholds
    $fatal(1, "air_quality_controller: thresholds must satisfy HUM_ON <= HUM_OFF < PUR_OFF <= PUR_ON");
  end

  logic [N_CH-1:0] hit, pur, hum, flt;

  // Out-of-range indices match no room, so they touch no state at all.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign hit[i] = bus.sample_valid && (bus.sample_ch == CH_W'(i));

    aq_channel_fsm #(
      .WIDTH  (WIDTH),
      .HUM_ON (HUM_ON),
      .HUM_OFF(HUM_OFF),
      .PUR_OFF(PUR_OFF),
      .PUR_ON (PUR_ON),
      .PERSIST(PERSIST),
      .MIN_ON (MIN_ON),
      .TIMEOUT(TIMEOUT)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .hit       (hit[i]),
      .sample    (bus.sample),
      .purifier  (pur[i]),
      .humidifier(hum[i]),
      .fault     (flt[i])
    );
  end

  assign bus.purifier   = pur;
  assign bus.humidifier = hum;
  assign bus.fault      = flt;

endmodule

// File: tb/tb_air_quality_controller.sv
// Directed bench: a vector table for the main sequences plus hand-written
// watchdog, mid-operation reset and out-of-range index sequences.
module tb_air_quality_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  air_quality_controller_if #(.WIDTH(8), .N_CH(2)) bus2 ();
  air_quality_controller_if #(.WIDTH(8), .N_CH(3)) bus3 ();

  air_quality_controller #(
    .WIDTH(8), .N_CH(2), .HUM_ON(30), .HUM_OFF(40), .PUR_OFF(80), .PUR_ON(100),
    .PERSIST(3), .MIN_ON(8), .TIMEOUT(50)
  ) dut (.clk(clk), .rst(rst), .bus(bus2));

  air_quality_controller #(
    .WIDTH(8), .N_CH(3), .HUM_ON(30), .HUM_OFF(40), .PUR_OFF(80), .PUR_ON(100),
    .PERSIST(3), .MIN_ON(8), .TIMEOUT(50)
  ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks   = 0;
  int failures = 0;

  typedef enum logic [1:0] {OP_RST, OP_SEND, OP_IDLE} op_e;
  typedef struct packed {
    op_e        op;
    logic       ch;
    logic [7:0] val;   // sample value, or idle cycle count
    logic [1:0] pur;
    logic [1:0] hum;
    logic [1:0] flt;
  } vec_t;

  vec_t vt[$];

  function automatic void add(op_e op, logic ch, logic [7:0] val,
                              logic [1:0] pur, logic [1:0] hum, logic [1:0] flt);
    vt.push_back('{op, ch, val, pur, hum, flt});
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send2(int ch, int val);
    bus2.sample_valid = 1'b1;
    bus2.sample_ch    = 1'(ch);
    bus2.sample       = 8'(val);
    tick(1);
    bus2.sample_valid = 1'b0;
  endtask

  task automatic send3(int ch, int val);
    bus3.sample_valid = 1'b1;
    bus3.sample_ch    = 2'(ch);
    bus3.sample       = 8'(val);
    tick(1);
    bus3.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus2.sample_valid = 1'b0;
    bus3.sample_valid = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic [8:0] out2();
    return {3'b000, bus2.purifier, bus2.humidifier, bus2.fault};
  endfunction

  function automatic logic [8:0] out3();
    return {bus3.purifier, bus3.humidifier, bus3.fault};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    bus2.sample_valid = 1'b0; bus2.sample_ch = '0; bus2.sample = '0;
    bus3.sample_valid = 1'b0; bus3.sample_ch = '0; bus3.sample = '0;

    // Purify entry on ch0, then release with a restarted count.
    add(OP_RST,  0,   0, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 0, 120, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 0, 120, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 0, 120, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  90, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  70, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  70, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  70, 2'b01, 2'b00, 2'b00);
    add(OP_IDLE, 0,   3, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  90, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  70, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  70, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 0,  70, 2'b00, 2'b00, 2'b00);
    // Humidify on ch1 with an interrupted run, release after MIN_ON, then purify.
    add(OP_RST,  0,   0, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  50, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b00, 2'b10, 2'b00);
    add(OP_SEND, 1,  45, 2'b00, 2'b10, 2'b00);
    add(OP_SEND, 1,  45, 2'b00, 2'b10, 2'b00);
    add(OP_SEND, 1,  45, 2'b00, 2'b10, 2'b00);
    add(OP_IDLE, 0,   6, 2'b00, 2'b10, 2'b00);
    add(OP_SEND, 1,  45, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1, 120, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1, 120, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1, 120, 2'b10, 2'b00, 2'b00);
    // Interleaved rooms keep independent counters.
    add(OP_RST,  0,   0, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 0, 120, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 0, 120, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b00, 2'b00, 2'b00);
    add(OP_SEND, 0, 120, 2'b01, 2'b00, 2'b00);
    add(OP_SEND, 1,  20, 2'b01, 2'b10, 2'b00);

    for (int i = 0; i < vt.size(); i++) begin
      case (vt[i].op)
        OP_RST:  do_reset();
        OP_SEND: send2(int'(vt[i].ch), int'(vt[i].val));
        default: tick(int'(vt[i].val));
      endcase
      check($sformatf("vec%0d", i), out2(), {3'b000, vt[i].pur, vt[i].hum, vt[i].flt});
    end

    // Watchdog expiry in PURIFY; ch1 never sampled so it faults at 50 too.
    do_reset();
    repeat (3) send2(0, 120);
    tick(49);
    check("wd_before_expiry", out2(), 9'b000_01_00_10);
    tick(1);
    check("wd_expiry_edge", out2(), 9'b000_00_00_11);
    send2(0, 120);
    check("wd_fault_clear", out2(), 9'b000_00_00_10);
    send2(0, 120);
    send2(0, 120);
    check("wd_clear_sample_not_counted", out2(), 9'b000_00_00_10);
    send2(0, 120);
    check("wd_repurify", out2(), 9'b000_01_00_10);

    // A sample landing on the expiry cycle keeps the room alive.
    do_reset();
    repeat (3) send2(0, 120);
    tick(49);
    send2(0, 120);
    check("wd_sample_wins", out2(), 9'b000_01_00_10);
    tick(1);
    check("wd_sample_wins_hold", out2(), 9'b000_01_00_10);

    // Reset in PURIFY before MIN_ON clears outputs and the persistence count.
    do_reset();
    repeat (3) send2(0, 120);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_mid_outputs", out2(), 9'b0);
    rst = 1'b0;
    send2(0, 120);
    send2(0, 120);
    check("rst_mid_counters", out2(), 9'b0);

    // Three-room instance: index 3 is out of range and kicks no watchdog.
    do_reset();
    repeat (3) send3(3, 120);
    check("oor_ignored", out3(), 9'b0);
    repeat (3) send3(2, 120);
    check("ch2_purify", out3(), 9'b100_000_000);
    for (int i = 1; i <= 50; i++) begin
      send3(3, 50);
      if (i == 49) check("oor_no_kick_e55", out3(), 9'b100_000_011);
      if (i == 50) check("oor_no_kick_e56", out3(), 9'b000_000_111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
